// File: rtl/contador_pkg.sv
// Shared types for the contador family: counting modes and direction encoding.
// Pure declarations, no logic.
package contador_pkg;

   typedef enum logic [1:0] {
      CRESCENTE   = 2'b00,
      DECRESCENTE = 2'b01,
      VAIVEM      = 2'b10,
      PARADO      = 2'b11
   } modo_t;

   localparam logic SENTIDO_SOBE  = 1'b0;
   localparam logic SENTIDO_DESCE = 1'b1;

endpackage

// File: rtl/contador_limites.sv
// Combinational limit comparator: flags saida at/outside the window and inverted limits.
// Zero latency, no flow control.
module contador_limites #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] saida,
   input  logic [WIDTH-1:0] limite_min,
   input  logic [WIDTH-1:0] limite_max,
   output logic             no_min,
   output logic             no_max,
   output logic             fora_faixa,
   output logic             erro
);

   assign no_min     = (saida == limite_min);
   assign no_max     = (saida == limite_max);
   assign fora_faixa = (saida < limite_min) || (saida > limite_max);
   assign erro       = (limite_min > limite_max);

endmodule

// File: rtl/contador_vaivem_param.sv
// Up/down/bounce counter with programmable limits; outputs registered (erro comb), one step per enabled edge.
// CONTADOR_VAIVEM_PAUSA_EN: bounce holds the limit value for one extra step on turnaround.
module contador_vaivem_param
   import contador_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  modo_t            modo,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limite_min,
   input  logic [WIDTH-1:0] limite_max,
   output logic [WIDTH-1:0] saida,
   output logic             sentido,
   output logic             extremo,
   output logic             erro
);

   localparam logic [WIDTH-1:0] UM = WIDTH'(1);

   logic             no_min;
   logic             no_max;
   logic             fora_faixa;
   logic [WIDTH-1:0] saida_nxt;
   logic             sentido_nxt;
   logic             extremo_nxt;
   logic [WIDTH-1:0] carga;
   logic             sobe;

   contador_limites #(.WIDTH(WIDTH)) u_limites (
      .saida      (saida),
      .limite_min (limite_min),
      .limite_max (limite_max),
      .no_min     (no_min),
      .no_max     (no_max),
      .fora_faixa (fora_faixa),
      .erro       (erro)
   );

   always_comb begin
      carga = load_value;
      if (load_value < limite_min)
         carga = limite_min;
      else if (load_value > limite_max)
         carga = limite_max;
   end

   // Effective direction of this step, before any sentido rewrite by the mode.
   assign sobe = (modo == CRESCENTE) || ((modo == VAIVEM) && (sentido == SENTIDO_SOBE));

   always_comb begin
      saida_nxt   = saida;
      sentido_nxt = sentido;
      extremo_nxt = 1'b0;
      if (erro) begin
         saida_nxt = saida;
      end else if (load) begin
         saida_nxt = carga;
      end else if (enable && (modo != PARADO)) begin
         if (modo == CRESCENTE)
            sentido_nxt = SENTIDO_SOBE;
         else if (modo == DECRESCENTE)
            sentido_nxt = SENTIDO_DESCE;

         if (fora_faixa) begin
            saida_nxt = sobe ? limite_min : limite_max;
         end else begin
            case (modo)
               CRESCENTE: begin
                  extremo_nxt = no_max;
                  saida_nxt   = no_max ? limite_min : saida + UM;
               end
               DECRESCENTE: begin
                  extremo_nxt = no_min;
                  saida_nxt   = no_min ? limite_max : saida - UM;
               end
               VAIVEM: begin
                  if (sobe ? no_max : no_min) begin
                     extremo_nxt = 1'b1;
                     sentido_nxt = ~sentido;
`ifdef CONTADOR_VAIVEM_PAUSA_EN
                     saida_nxt   = saida;
`else
                     // min == max makes both flags true: stay put.
                     if (sobe)
                        saida_nxt = no_min ? saida : saida - UM;
                     else
                        saida_nxt = no_max ? saida : saida + UM;
`endif
                  end else begin
                     saida_nxt = sobe ? saida + UM : saida - UM;
                  end
               end
               default: saida_nxt = saida;
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         saida   <= '0;
         sentido <= SENTIDO_SOBE;
         extremo <= 1'b0;
      end else begin
         saida   <= saida_nxt;
         sentido <= sentido_nxt;
         extremo <= extremo_nxt;
      end
   end

endmodule

// File: tb/tb_contador_vaivem_param.sv
// Directed + random bench for contador_vaivem_param (WIDTH=5) against a value/direction reference model.
// Honours CONTADOR_VAIVEM_PAUSA_EN in the model.
module tb_contador_vaivem_param;
   import contador_pkg::*;

   localparam int W = 5;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   modo_t        modo = CRESCENTE;
   logic         load = 1'b0;
   logic [W-1:0] load_value = '0;
   logic [W-1:0] limite_min = '0;
   logic [W-1:0] limite_max = '0;
   logic [W-1:0] saida;
   logic         sentido;
   logic         extremo;
   logic         erro;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: plain integers, range rules applied arithmetically.
   int m_val = 0;
   bit m_dir = 1'b0;
   bit m_ext = 1'b0;

   contador_vaivem_param #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .modo       (modo),
      .load       (load),
      .load_value (load_value),
      .limite_min (limite_min),
      .limite_max (limite_max),
      .saida      (saida),
      .sentido    (sentido),
      .extremo    (extremo),
      .erro       (erro)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelo(input bit en, input modo_t md, input bit ld, input int lv,
                         input int mn, input int mx);
      bit up;
      int alvo;
      m_ext = 1'b0;
      if (mn > mx) return;
      if (ld) begin
         m_val = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
         return;
      end
      if (!en || md == PARADO) return;
      up = (md == CRESCENTE) || (md == VAIVEM && !m_dir);
      if (md == CRESCENTE) m_dir = 1'b0;
      if (md == DECRESCENTE) m_dir = 1'b1;
      if (m_val < mn || m_val > mx) begin
         m_val = up ? mn : mx;
         return;
      end
      alvo = up ? m_val + 1 : m_val - 1;
      if (alvo >= mn && alvo <= mx) begin
         m_val = alvo;
      end else begin
         m_ext = 1'b1;
         if (md == CRESCENTE) m_val = mn;
         else if (md == DECRESCENTE) m_val = mx;
         else begin
            m_dir = !m_dir;
`ifndef CONTADOR_VAIVEM_PAUSA_EN
            if (mn != mx) m_val = up ? m_val - 1 : m_val + 1;
`endif
         end
      end
   endtask

   task automatic passo(input string tag, input bit en, input modo_t md, input bit ld,
                        input int lv, input int mn, input int mx);
      enable     = en;
      modo       = md;
      load       = ld;
      load_value = lv[W-1:0];
      limite_min = mn[W-1:0];
      limite_max = mx[W-1:0];
      @(posedge clock);
      modelo(en, md, ld, lv, mn, mx);
      #1;
      chk({tag, ".saida"}, 32'(saida), 32'(m_val));
      chk({tag, ".sentido"}, 32'(sentido), 32'(m_dir));
      chk({tag, ".extremo"}, 32'(extremo), 32'(m_ext));
      chk({tag, ".erro"}, 32'(erro), 32'(mn > mx));
   endtask

   task automatic reinicia();
      #2 reset = 1'b0;
      #1;
      m_val = 0; m_dir = 1'b0; m_ext = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      int exp_cres[5];
      int exp_dec[4];
      bit dir_ant;
      int a, b, mn, mx;

      // Reset state
      #12;
      chk("reset.saida", 32'(saida), 0);
      chk("reset.sentido", 32'(sentido), 0);
      chk("reset.extremo", 32'(extremo), 0);
      @(negedge clock);
      reset = 1'b1;

      // CRESCENTE 3..6: first step lifts 0 into range
      exp_cres = '{3, 4, 5, 6, 3};
      for (int i = 0; i < 5; i++) begin
         passo("cres", 1'b1, CRESCENTE, 1'b0, 0, 3, 6);
         chk("cres.seq", 32'(saida), 32'(exp_cres[i]));
         chk("cres.ext", 32'(extremo), 32'(i == 4));
      end
      passo("cres_hold", 1'b0, CRESCENTE, 1'b0, 0, 3, 6);
      chk("cres.ext_one_cycle", 32'(extremo), 0);

      // VAIVEM 0..15 from reset, through both turnarounds
      reinicia();
      for (int i = 0; i < 40; i++)
         passo("vaivem", 1'b1, VAIVEM, 1'b0, 0, 0, 15);

      // Load clamp, load beats enable
      passo("load_hi", 1'b1, VAIVEM, 1'b1, 20, 2, 9);
      chk("load.clamp_hi", 32'(saida), 9);
      passo("load_lo", 1'b1, CRESCENTE, 1'b1, 0, 2, 9);
      chk("load.clamp_lo", 32'(saida), 2);

      // Runtime limit change leaves saida out of range
      passo("dec_load", 1'b0, DECRESCENTE, 1'b1, 3, 0, 15);
      exp_dec = '{10, 9, 8, 10};
      for (int i = 0; i < 4; i++) begin
         passo("dec", 1'b1, DECRESCENTE, 1'b0, 0, 8, 10);
         chk("dec.seq", 32'(saida), 32'(exp_dec[i]));
         chk("dec.ext", 32'(extremo), 32'(i == 3));
      end

      // Inverted limits freeze the counter
      passo("erro", 1'b1, CRESCENTE, 1'b1, 1, 7, 4);
      chk("erro.flag", 32'(erro), 1);
      chk("erro.frozen", 32'(saida), 10);

      // min == max in VAIVEM
      passo("igual_load", 1'b0, VAIVEM, 1'b1, 0, 5, 5);
      for (int i = 0; i < 4; i++) begin
         dir_ant = sentido;
         passo("igual", 1'b1, VAIVEM, 1'b0, 0, 5, 5);
         chk("igual.val", 32'(saida), 5);
         chk("igual.toggle", 32'(sentido), 32'(!dir_ant));
         chk("igual.ext", 32'(extremo), 1);
      end

      // Randomized traffic
      mn = 0; mx = 15;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom_range(0, 31);
            b = $urandom_range(0, 31);
            mn = (a < b) ? a : b;
            mx = (a < b) ? b : a;
            if ($urandom_range(0, 15) == 0) begin
               mn = mx + 1 > 31 ? 31 : mx + 1;
               mx = mx > 0 ? mx - 1 : 0;
            end
         end
         passo("rand", $urandom_range(0, 3) != 0, modo_t'($urandom_range(0, 3)),
               $urandom_range(0, 15) == 0, $urandom_range(0, 31), mn, mx);
      end

      // Asynchronous reset between edges, then resume from 0
      passo("pre_rst_load", 1'b0, CRESCENTE, 1'b1, 12, 0, 15);
      passo("pre_rst", 1'b1, DECRESCENTE, 1'b0, 0, 0, 15);
      #2 reset = 1'b0;
      #1;
      chk("midrst.saida", 32'(saida), 0);
      chk("midrst.sentido", 32'(sentido), 0);
      chk("midrst.extremo", 32'(extremo), 0);
      m_val = 0; m_dir = 1'b0; m_ext = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      passo("post_rst", 1'b1, CRESCENTE, 1'b0, 0, 0, 15);
      chk("post_rst.first", 32'(saida), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
